mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single genrom/memory read port between the core's instruction-fetch requester and its data (load) requester. Each requester uses a req/valid hold handshake. The arbiter picks a winner, drives and holds the memory address, extra and bounds for the configured read latency, then captures mem_data/mem_error and returns them to the winner with a one-cycle valid pulse. It sits between core and genrom, replacing their direct mem_addr/mem_extra/mem_data/mem_error connection.

Parameters:
MEM_DEPTH, 3, address MSB index; address/bound buses are MEM_DEPTH+1 bits (matches core MEM_DEPTH and genrom AW).
MEM_EXTRA, 4, extra field width; data bus is 2**MEM_EXTRA*8 bits.
READ_LATENCY, 1, memory cycles from address presented to mem_data valid (0 = combinational memory).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
fetch_req  in  1  fetch requester wants a read; held until fetch_valid
fetch_addr  in  MEM_DEPTH+1  fetch address
fetch_extra  in  MEM_EXTRA  fetch extra/size field
fetch_lower_bound  in  MEM_DEPTH+1  fetch region lower bound
fetch_upper_bound  in  MEM_DEPTH+1  fetch region upper bound
fetch_valid  out  1  one-cycle pulse: fetch response present
fetch_data  out  2**MEM_EXTRA*8  fetch response data
fetch_error  out  1  fetch response error
data_req, data_addr, data_extra, data_lower_bound, data_upper_bound  in  (as fetch_*)  load requester
data_valid, data_data, data_error  out  (as fetch_*)  load response
mem_addr  out  MEM_DEPTH+1  to genrom addr
mem_extra  out  MEM_EXTRA  to genrom extra
mem_lower_bound  out  MEM_DEPTH+1  to genrom lower_bound
mem_upper_bound  out  MEM_DEPTH+1  to genrom upper_bound
mem_data  in  2**MEM_EXTRA*8  from genrom data
mem_error  in  1  from genrom error
busy  out  1  high in ISSUE and RESP

Behaviour:
- Reset (synchronous, on clk posedge with reset=1): state=IDLE; all mem_* = 0; fetch_valid = data_valid = 0; *_data = 0; *_error = 0; busy = 0; round-robin pointer prefers fetch. Reset mid-transaction aborts it with no valid pulse.
- States: IDLE, ISSUE, RESP.
- IDLE: at the posedge, if any req is high, select a winner. The winner's addr/extra/bounds are latched into the mem_* registers, cnt=0, state goes to ISSUE. With no req, stay in IDLE and hold mem_* at their last values.
- Arbitration: if only one requester is asserting, it wins. If both are asserting, the requester not served last wins (round-robin). After reset, fetch is preferred.
- ISSUE: mem_* held constant. Each posedge increments cnt. At the posedge where cnt==READ_LATENCY, mem_data/mem_error are captured into the winner's *_data/*_error registers and state goes to RESP. ISSUE lasts READ_LATENCY+1 cycles.
- RESP: the winner's *_valid is 1 for exactly one cycle. The loser's valid stays 0. Next state is IDLE. Arbitration resumes at the following IDLE cycle.
- Latency: req first sampled in IDLE (cycle 0) -> valid in cycle READ_LATENCY+2. Throughput is one access per READ_LATENCY+3 cycles under continuous demand.
- *_data/*_error hold the last captured value until that requester's next capture. The loser's registers are never modified.
- Requests arriving while busy wait; nothing is queued beyond the held req.
- If req is deasserted after a grant, the transaction still completes and valid still pulses. The requester ignores it.
- Requester inputs are sampled only in IDLE at the grant edge. Later changes have no effect on the active transaction.
- Bounds checking is performed by genrom. mem_error is passed through unchanged.

Optional Feature:
MEM_ARB_FIXED_PRIO_EN: when defined, fetch always wins simultaneous requests; the round-robin pointer is removed and data can starve. When undefined, round-robin arbitration as specified above.

Test Plan:
Bench memory model: READ_LATENCY=1; registered mem_data = mem_addr*0x11 zero-extended; mem_error = (mem_addr<mem_lower_bound || mem_addr>mem_upper_bound).
Single fetch: fetch_req=1, fetch_addr=3, bounds 0..15 in cycle 0 -> mem_addr=3 in cycles 1-2; fetch_valid=1 only in cycle 3 with fetch_data=0x33 and fetch_error=0; data_valid stays 0.
Collision after reset: fetch_addr=2 and data_addr=5 both asserted in cycle 0 -> fetch served first (valid cycle 3, data 0x22), then data (valid cycle 7, data 0x55).
Fairness: both reqs held continuously for 4 transactions -> grant order fetch, data, fetch, data; no requester is served twice in a row. With MEM_ARB_FIXED_PRIO_EN: the order is fetch x4.
Bounds error: data_addr=9, data_lower_bound=0, data_upper_bound=7 -> data_valid pulse with data_error=1.
Reset mid-operation: reset=1 in cycle 2 of a fetch -> no fetch_valid; mem_addr=0, busy=0 next cycle; a new request after reset completes with normal latency.
Hold/ignore: data_addr changed from 4 to 6 during ISSUE -> response data 0x44; fetch_data keeps its previous value.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory read port between an instruction-fetch
// requester and a data (load) requester. A winner is picked in IDLE, its
// address/extra/bounds are held on mem_* for READ_LATENCY+1 cycles (ISSUE),
// then mem_data/mem_error are captured and returned with a one-cycle valid
// pulse (RESP).
// Optional feature: define MEM_ARB_FIXED_PRIO_EN to make fetch always win
// simultaneous requests (no round-robin pointer; data may starve).
module mem_arbiter #(
  parameter int MEM_DEPTH    = 3,
  parameter int MEM_EXTRA    = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fetch_req,
  input  logic [MEM_DEPTH:0]               fetch_addr,
  input  logic [MEM_EXTRA-1:0]             fetch_extra,
  input  logic [MEM_DEPTH:0]               fetch_lower_bound,
  input  logic [MEM_DEPTH:0]               fetch_upper_bound,
  output logic                             fetch_valid,
  output logic [(2**MEM_EXTRA)*8-1:0]      fetch_data,
  output logic                             fetch_error,
  input  logic                             data_req,
  input  logic [MEM_DEPTH:0]               data_addr,
  input  logic [MEM_EXTRA-1:0]             data_extra,
  input  logic [MEM_DEPTH:0]               data_lower_bound,
  input  logic [MEM_DEPTH:0]               data_upper_bound,
  output logic                             data_valid,
  output logic [(2**MEM_EXTRA)*8-1:0]      data_data,
  output logic                             data_error,
  output logic [MEM_DEPTH:0]               mem_addr,
  output logic [MEM_EXTRA-1:0]             mem_extra,
  output logic [MEM_DEPTH:0]               mem_lower_bound,
  output logic [MEM_DEPTH:0]               mem_upper_bound,
  input  logic [(2**MEM_EXTRA)*8-1:0]      mem_data,
  input  logic                             mem_error,
  output logic                             busy
);

  localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sel_data;    // current winner: 1 = data, 0 = fetch
  logic             grant_data;  // winner chosen this cycle if a grant happens

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Fixed priority: data wins only when fetch is not asking
  always_comb begin
    grant_data = data_req & ~fetch_req;
  end
`else
  logic last_data;  // 1 when the most recent grant went to data

  // Round-robin: a lone requester wins; on collision the one not served last wins
  always_comb begin
    grant_data = (data_req & ~fetch_req) | (data_req & fetch_req & ~last_data);
  end
`endif

  // Arbitration FSM with registered memory-side and response-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      sel_data        <= 1'b0;
      mem_addr        <= '0;
      mem_extra       <= '0;
      mem_lower_bound <= '0;
      mem_upper_bound <= '0;
      fetch_valid     <= 1'b0;
      fetch_data      <= '0;
      fetch_error     <= 1'b0;
      data_valid      <= 1'b0;
      data_data       <= '0;
      data_error      <= 1'b0;
      busy            <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_data       <= 1'b1;  // makes fetch the preferred side after reset
`endif
    end else begin
      fetch_valid <= 1'b0;
      data_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_req || data_req) begin
            sel_data <= grant_data;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_data <= grant_data;
`endif
            if (grant_data) begin
              mem_addr        <= data_addr;
              mem_extra       <= data_extra;
              mem_lower_bound <= data_lower_bound;
              mem_upper_bound <= data_upper_bound;
            end else begin
              mem_addr        <= fetch_addr;
              mem_extra       <= fetch_extra;
              mem_lower_bound <= fetch_lower_bound;
              mem_upper_bound <= fetch_upper_bound;
            end
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(READ_LATENCY)) begin
            if (sel_data) begin
              data_data  <= mem_data;
              data_error <= mem_error;
              data_valid <= 1'b1;
            end else begin
              fetch_data  <= mem_data;
              fetch_error <= mem_error;
              fetch_valid <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected responses,
// a forked monitor pops and compares whenever a valid pulse appears.
module tb_mem_arbiter;

  localparam int MEM_DEPTH = 3;
  localparam int MEM_EXTRA = 4;
  localparam int AW = MEM_DEPTH + 1;
  localparam int DW = (2**MEM_EXTRA) * 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req, data_req;
  logic [AW-1:0] fetch_addr, fetch_lower_bound, fetch_upper_bound;
  logic [AW-1:0] data_addr, data_lower_bound, data_upper_bound;
  logic [MEM_EXTRA-1:0] fetch_extra, data_extra, mem_extra;
  logic          fetch_valid, fetch_error, data_valid, data_error;
  logic [DW-1:0] fetch_data, data_data, mem_data;
  logic [AW-1:0] mem_addr, mem_lower_bound, mem_upper_bound;
  logic          mem_error, busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    bit          is_data;
    logic [DW-1:0] d;
    bit          e;
    int          at;
  } exp_t;
  exp_t sb[$];

  mem_arbiter #(.MEM_DEPTH(MEM_DEPTH), .MEM_EXTRA(MEM_EXTRA), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_extra(fetch_extra),
    .fetch_lower_bound(fetch_lower_bound), .fetch_upper_bound(fetch_upper_bound),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_error(fetch_error),
    .data_req(data_req), .data_addr(data_addr), .data_extra(data_extra),
    .data_lower_bound(data_lower_bound), .data_upper_bound(data_upper_bound),
    .data_valid(data_valid), .data_data(data_data), .data_error(data_error),
    .mem_addr(mem_addr), .mem_extra(mem_extra),
    .mem_lower_bound(mem_lower_bound), .mem_upper_bound(mem_upper_bound),
    .mem_data(mem_data), .mem_error(mem_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // cycle index: number of posedges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  // registered memory model, one cycle of read latency
  always @(posedge clk) begin
    mem_data  <= DW'(mem_addr) * DW'(8'h11);
    mem_error <= (mem_addr < mem_lower_bound) || (mem_addr > mem_upper_bound);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_resp(input bit is_data, input logic [DW-1:0] d, input bit e, input int at);
    exp_t x;
    x.is_data = is_data; x.d = d; x.e = e; x.at = at;
    sb.push_back(x);
  endtask

  task automatic monitor();
    exp_t x;
    forever begin
      @(negedge clk);
      if (fetch_valid === 1'b1 || data_valid === 1'b1) begin
        n_vec++;
        if (fetch_valid === 1'b1 && data_valid === 1'b1) begin
          n_err++;
          $display("FAIL both_valid: fetch_valid and data_valid together at cycle %0d", cyc);
        end else if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_resp: %s valid at cycle %0d with nothing expected",
                   data_valid ? "data" : "fetch", cyc);
        end else begin
          x = sb.pop_front();
          if (data_valid !== x.is_data ||
              (x.is_data ? data_data : fetch_data) !== x.d ||
              (x.is_data ? data_error : fetch_error) !== x.e ||
              cyc != x.at) begin
            n_err++;
            $display("FAIL resp: got %s data=%0h err=%0b cycle=%0d expected %s data=%0h err=%0b cycle=%0d",
                     data_valid ? "data" : "fetch",
                     data_valid ? data_data : fetch_data,
                     data_valid ? data_error : fetch_error, cyc,
                     x.is_data ? "data" : "fetch", x.d, x.e, x.at);
          end
        end
      end
    end
  endtask

  task automatic wait_valid(input bit is_data);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if ((is_data ? data_valid : fetch_valid) === 1'b1) seen = 1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: no %s valid within 20 cycles, got none required one", is_data ? "data" : "fetch");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    int c0;
    reset = 1'b1;
    fetch_req = 0; fetch_addr = 0; fetch_extra = 4'h2; fetch_lower_bound = 0; fetch_upper_bound = 0;
    data_req = 0; data_addr = 0; data_extra = 4'h3; data_lower_bound = 0; data_upper_bound = 0;
    fork
      monitor();
    join_none

    // reset state
    repeat (2) tick();
    chk("rst_busy", DW'(busy), 0);
    chk("rst_mem_addr", DW'(mem_addr), 0);
    chk("rst_valids", DW'({fetch_valid, data_valid}), 0);
    chk("rst_fetch_data", fetch_data, 0);
    chk("rst_data_data", data_data, 0);
    reset = 1'b0;
    tick();

    // single fetch
    fetch_req = 1; fetch_addr = 4'd3; fetch_lower_bound = 0; fetch_upper_bound = 4'd15;
    c0 = cyc;
    expect_resp(0, DW'(8'h33), 0, c0 + 3);
    tick();
    chk("single_mem_addr_c1", DW'(mem_addr), 3);
    chk("single_busy_c1", DW'(busy), 1);
    chk("single_mem_extra_c1", DW'(mem_extra), 2);
    tick();
    chk("single_mem_addr_c2", DW'(mem_addr), 3);
    tick();
    fetch_req = 0;
    tick();
    chk("single_busy_after", DW'(busy), 0);
    chk("single_data_untouched", data_data, 0);

    // collision right after reset: fetch first, then data
    do_reset();
    tick();
    fetch_req = 1; fetch_addr = 4'd2; fetch_lower_bound = 0; fetch_upper_bound = 4'd15;
    data_req = 1; data_addr = 4'd5; data_lower_bound = 0; data_upper_bound = 4'd15;
    c0 = cyc;
    expect_resp(0, DW'(8'h22), 0, c0 + 3);
    expect_resp(1, DW'(8'h55), 0, c0 + 7);
    wait_valid(0);
    fetch_req = 0;
    wait_valid(1);
    data_req = 0;
    tick();

    // fairness: both held for four transactions
    fetch_req = 1; fetch_addr = 4'd1;
    data_req = 1; data_addr = 4'd6;
    c0 = cyc;
`ifdef MEM_ARB_FIXED_PRIO_EN
    expect_resp(0, DW'(8'h11), 0, c0 + 3);
    expect_resp(0, DW'(8'h11), 0, c0 + 7);
    expect_resp(0, DW'(8'h11), 0, c0 + 11);
    expect_resp(0, DW'(8'h11), 0, c0 + 15);
`else
    expect_resp(0, DW'(8'h11), 0, c0 + 3);
    expect_resp(1, DW'(8'h66), 0, c0 + 7);
    expect_resp(0, DW'(8'h11), 0, c0 + 11);
    expect_resp(1, DW'(8'h66), 0, c0 + 15);
`endif
    repeat (15) tick();
    fetch_req = 0; data_req = 0;
    repeat (2) tick();

    // bounds error on the data side
    data_req = 1; data_addr = 4'd9; data_lower_bound = 0; data_upper_bound = 4'd7;
    c0 = cyc;
    expect_resp(1, DW'(8'h99), 1, c0 + 3);
    wait_valid(1);
    data_req = 0;
    tick();

    // reset in the middle of a fetch
    fetch_req = 1; fetch_addr = 4'd3; fetch_lower_bound = 0; fetch_upper_bound = 4'd15;
    tick();
    tick();
    reset = 1'b1; fetch_req = 0;
    tick();
    chk("midrst_mem_addr", DW'(mem_addr), 0);
    chk("midrst_busy", DW'(busy), 0);
    chk("midrst_fetch_data", fetch_data, 0);
    reset = 1'b0;
    repeat (3) tick();
    fetch_req = 1; fetch_addr = 4'd7;
    c0 = cyc;
    expect_resp(0, DW'(8'h77), 0, c0 + 3);
    wait_valid(0);
    fetch_req = 0;
    tick();

    // requester inputs changed during ISSUE are ignored
    data_req = 1; data_addr = 4'd4; data_lower_bound = 0; data_upper_bound = 4'd15;
    c0 = cyc;
    expect_resp(1, DW'(8'h44), 0, c0 + 3);
    tick();
    data_addr = 4'd6;
    tick();
    chk("hold_mem_addr", DW'(mem_addr), 4);
    wait_valid(1);
    data_req = 0;
    tick();
    chk("hold_data_data", data_data, DW'(8'h44));
    chk("hold_fetch_data_kept", fetch_data, DW'(8'h77));

    repeat (4) tick();
    chk("scoreboard_drained", DW'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
